// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick_sched scheduler.
package tick_sched_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_PRE_W = 16;

  typedef enum logic [0:0] {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_t;

  // Per-channel state; counters are sized to the default channel width.
  typedef struct packed {
    logic                 enabled;
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_CNT_W-1:0] cnt;
  } chan_t;

endpackage

// File: rtl/tick_sched_rr_arbiter.sv
// Combinational round-robin pick: first requesting index after i_ptr, wrapping.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [CH_W-1:0] o_grant_c,
  output logic            o_any_req_c
);

  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    o_grant_c   = '0;
    o_any_req_c = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int i = N_CH; i >= 1; i--) begin
      w_sum = {1'b0, i_ptr} + (CH_W+1)'(i);
      if (w_sum >= (CH_W+1)'(N_CH)) begin
        w_sum = w_sum - (CH_W+1)'(N_CH);
      end
      w_idx = CH_W'(w_sum);
      if (i_req[w_idx]) begin
        o_grant_c   = w_idx;
        o_any_req_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// tick_sched: one shared prescaler driving N_CH periodic channels whose expiries
// are delivered round-robin on a valid/ready port. Define TICK_SCHED_OVERRUN_EN
// to add sticky per-channel overrun flags.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned CNT_W = DEF_CNT_W,
  parameter  int unsigned PRE_W = DEF_PRE_W,
  localparam int unsigned CH_W  = $clog2(N_CH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PRE_W-1:0] prescale,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_enable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_chan,
  output logic [N_CH-1:0]  pending
`ifdef TICK_SCHED_OVERRUN_EN
  ,
  output logic [N_CH-1:0]  overrun
`endif
);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_base_tick;

  // Channel counters live in the package struct, so CNT_W is expected to match it.
  chan_t            r_chan [N_CH];
  logic [N_CH-1:0]  w_expire;
  logic [N_CH-1:0]  r_pending;
  logic [N_CH-1:0]  w_pend_nxt;

  cfg_state_t       r_cfg_state;
  logic             r_cfg_ready;
  logic [CH_W-1:0]  r_cfg_chan;
  logic [CNT_W-1:0] r_cfg_period;
  logic             r_cfg_enable;
  logic             w_apply;

  logic             r_evt_valid;
  logic [CH_W-1:0]  r_evt_chan;
  logic [CH_W-1:0]  r_ptr;
  logic             w_slot_free;
  logic             w_any_req;
  logic             w_take;
  logic [CH_W-1:0]  w_gnt;

  assign w_base_tick = (r_pre_cnt >= prescale);
  assign w_apply     = (r_cfg_state == CFG_APPLY);
  assign w_slot_free = !r_evt_valid || evt_ready;
  assign w_take      = w_slot_free && w_any_req;

  assign cfg_ready = r_cfg_ready;
  assign evt_valid = r_evt_valid;
  assign evt_chan  = r_evt_chan;
  assign pending   = r_pending;

  // Prescaler; >= compare recovers at once if prescale drops below the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (w_base_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  // A config write in progress masks that channel's expiry for the clock.
  always_comb begin
    w_expire = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_expire[i] = w_base_tick && r_chan[i].enabled && (r_chan[i].cnt == '0)
                    && !(w_apply && (r_cfg_chan == CH_W'(i)));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_chan[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_apply && (r_cfg_chan == CH_W'(i))) begin
          r_chan[i].enabled <= r_cfg_enable;
          r_chan[i].period  <= DEF_CNT_W'(r_cfg_period);
          r_chan[i].cnt     <= DEF_CNT_W'(r_cfg_period);
        end else if (w_base_tick && r_chan[i].enabled) begin
          r_chan[i].cnt <= (r_chan[i].cnt == '0) ? r_chan[i].period
                                                 : r_chan[i].cnt - DEF_CNT_W'(1);
        end
      end
    end
  end

  // Config handshake: accept in IDLE, commit to the channel array in APPLY.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_state  <= CFG_IDLE;
      r_cfg_ready  <= 1'b1;
      r_cfg_chan   <= '0;
      r_cfg_period <= '0;
      r_cfg_enable <= 1'b0;
    end else begin
      case (r_cfg_state)
        CFG_IDLE: begin
          if (cfg_valid) begin
            r_cfg_chan   <= cfg_chan;
            r_cfg_period <= cfg_period;
            r_cfg_enable <= cfg_enable;
            r_cfg_state  <= CFG_APPLY;
            r_cfg_ready  <= 1'b0;
          end
        end
        CFG_APPLY: begin
          r_cfg_state <= CFG_IDLE;
          r_cfg_ready <= 1'b1;
        end
        default: begin
          r_cfg_state <= CFG_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Expiry is applied last so a same-clock grant leaves a fresh pending flag.
  always_comb begin
    w_pend_nxt = r_pending;
    for (int i = 0; i < N_CH; i++) begin
      if ((w_take && (w_gnt == CH_W'(i))) || (w_apply && (r_cfg_chan == CH_W'(i)))) begin
        w_pend_nxt[i] = 1'b0;
      end
      if (w_expire[i]) begin
        w_pend_nxt[i] = 1'b1;
      end
    end
  end

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .i_req       (r_pending),
    .i_ptr       (r_ptr),
    .o_grant_c   (w_gnt),
    .o_any_req_c (w_any_req)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_evt_valid <= 1'b0;
      r_evt_chan  <= '0;
      r_ptr       <= CH_W'(N_CH - 1);
    end else begin
      r_pending <= w_pend_nxt;
      if (w_slot_free) begin
        r_evt_valid <= w_any_req;
        if (w_any_req) begin
          r_evt_chan <= w_gnt;
          r_ptr      <= w_gnt;
        end
      end
    end
  end

`ifdef TICK_SCHED_OVERRUN_EN
  logic [N_CH-1:0] r_overrun;

  assign overrun = r_overrun;

  // Sticky until the channel is rewritten.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_apply && (r_cfg_chan == CH_W'(i))) begin
          r_overrun[i] <= 1'b0;
        end else if (w_expire[i] && r_pending[i]) begin
          r_overrun[i] <= 1'b1;
        end
      end
    end
  end
`else
  // Overruns are dropped silently; the pending flag simply stays set.
`endif

endmodule
